des_round_key_sequencer: RTL and testbench

//  Sequential DES key schedule. Loads one 64-bit key and streams the 16 48-bit round keys over a valid/ready handshake.

---
 rtl/des_round_key_sequencer.sv | 138 +++++++++++++
 tb/tb_des_round_key_sequencer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_round_key_sequencer.sv
// rtl/des_round_key_sequencer.sv - DES key schedule streaming 16 round keys over valid/ready
module des_round_key_sequencer #(
    parameter bit PARITY_CHECK = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_decrypt,
    input  logic [63:0] i_64bit_key,
    input  logic        i_ready,
    output logic        o_valid,
    output logic [47:0] o_48bit_key,
    output logic [3:0]  o_round,
    output logic        o_last,
    output logic        o_busy,
    output logic        o_parity_err
);

    typedef enum logic {IDLE, EMIT} state_t;

    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    state_t      state;
    logic [27:0] c;
    logic [27:0] d;
    logic [3:0]  round;
    logic        dec;
    logic        parity_ok;
    logic [55:0] pc1_key;
    logic [3:0]  next_idx;

    // Table entries use DES numbering: bit 1 is the MSB of the vector.
    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++) r[6'(55 - i)] = k[6'(64 - PC1_TAB[i])];
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < 48; i++) r[6'(47 - i)] = cd[6'(56 - PC2_TAB[i])];
        return r;
    endfunction

    // 0-based schedule index: entries 0, 1, 8 and 15 shift by one, the rest by two.
    function automatic logic shift_two(input logic [3:0] idx);
        return !(idx == 4'd0 || idx == 4'd1 || idx == 4'd8 || idx == 4'd15);
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    always_comb begin
        parity_ok = 1'b1;
        for (int b = 0; b < 8; b++) begin
            if (!(^i_64bit_key[8*b +: 8])) parity_ok = 1'b0;
        end
    end

    assign pc1_key     = pc1(i_64bit_key);
    assign next_idx    = round + 4'd1;
    assign o_valid     = (state == EMIT);
    assign o_busy      = (state == EMIT);
    assign o_round     = round;
    assign o_48bit_key = pc2({c, d});
    assign o_last      = o_valid & (dec ? (round == 4'd0) : (round == 4'd15));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            c            <= '0;
            d            <= '0;
            round        <= '0;
            dec          <= 1'b0;
            o_parity_err <= 1'b0;
        end else begin
            o_parity_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        if (PARITY_CHECK && !parity_ok) begin
                            o_parity_err <= 1'b1;
                        end else begin
                            dec   <= i_decrypt;
                            state <= EMIT;
                            if (i_decrypt) begin
                                c     <= pc1_key[55:28];
                                d     <= pc1_key[27:0];
                                round <= 4'd15;
                            end else begin
                                c     <= rotl(pc1_key[55:28], 1'b0);
                                d     <= rotl(pc1_key[27:0], 1'b0);
                                round <= 4'd0;
                            end
                        end
                    end
                end
                EMIT: begin
                    // The final key leaves C,D untouched: they already sit at C0/C1.
                    if (i_ready) begin
                        if (o_last) begin
                            state <= IDLE;
                        end else if (dec) begin
                            c     <= rotr(c, shift_two(round));
                            d     <= rotr(d, shift_two(round));
                            round <= round - 4'd1;
                        end else begin
                            c     <= rotl(c, shift_two(next_idx));
                            d     <= rotl(d, shift_two(next_idx));
                            round <= next_idx;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_des_round_key_sequencer.sv
// tb/tb_des_round_key_sequencer.sv - self-checking bench for des_round_key_sequencer
module tb_des_round_key_sequencer;

    localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_B = 64'h0E329232EA6D0D73;

    localparam int B_PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int B_PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int B_SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    logic        clk;
    logic        rst;
    logic        start;
    logic        decrypt;
    logic [63:0] key;
    logic        ready;
    logic        valid, last, busy, perr;
    logic [47:0] k48;
    logic [3:0]  round;
    logic        np_valid, np_last, np_busy, np_perr;
    logic [47:0] np_k48;
    logic [3:0]  np_round;

    des_round_key_sequencer #(.PARITY_CHECK(1'b1)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_decrypt(decrypt),
        .i_64bit_key(key), .i_ready(ready), .o_valid(valid), .o_48bit_key(k48),
        .o_round(round), .o_last(last), .o_busy(busy), .o_parity_err(perr)
    );

    des_round_key_sequencer #(.PARITY_CHECK(1'b0)) dut_np (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_decrypt(decrypt),
        .i_64bit_key(key), .i_ready(ready), .o_valid(np_valid), .o_48bit_key(np_k48),
        .o_round(np_round), .o_last(np_last), .o_busy(np_busy), .o_parity_err(np_perr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int checks = 0;
    int passes = 0;
    int hs_count = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference schedule: C_i/D_i are C0/D0 rotated left by the running sum of shifts.
    function automatic logic [55:0] m_pc1(input logic [63:0] k);
        logic [55:0] r;
        for (int i = 0; i < 56; i++) r[55 - i] = k[64 - B_PC1[i]];
        return r;
    endfunction

    function automatic logic [47:0] m_pc2(input logic [55:0] cd);
        logic [47:0] r;
        for (int i = 0; i < 48; i++) r[47 - i] = cd[56 - B_PC2[i]];
        return r;
    endfunction

    function automatic logic [27:0] m_rot(input logic [27:0] x, input int n);
        logic [55:0] t;
        t = {x, x} << (n % 28);
        return t[55:28];
    endfunction

    function automatic bit m_parity_ok(input logic [63:0] k);
        for (int b = 0; b < 8; b++) begin
            if ($countones(k[8*b +: 8]) % 2 == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    logic [47:0] m_keys [16];
    logic [47:0] m_c0d0_key;
    logic [47:0] m_idle_key;
    bit          m_init = 1'b0;
    bit          m_busy = 1'b0;
    bit          m_dec  = 1'b0;
    bit          m_perr = 1'b0;
    bit          m_zero = 1'b0;
    int          m_cnt  = 0;

    task automatic build(input logic [63:0] k);
        logic [55:0] cd;
        int tot;
        cd = m_pc1(k);
        tot = 0;
        m_c0d0_key = m_pc2(cd);
        for (int r = 0; r < 16; r++) begin
            tot += B_SH[r];
            m_keys[r] = m_pc2({m_rot(cd[55:28], tot), m_rot(cd[27:0], tot)});
        end
    endtask

    // Compare against the model, then advance it with the inputs the next edge will sample.
    always @(negedge clk) begin
        int exp_round;
        if (m_init) begin
            check("valid", valid, m_busy);
            check("busy", busy, m_busy);
            check("parity_err", perr, m_perr);
            if (m_busy) begin
                exp_round = m_dec ? 15 - m_cnt : m_cnt;
                check("key", k48, m_keys[exp_round]);
                check("round", round, exp_round);
                check("last", last, m_cnt == 15);
            end else begin
                check("idle_key", k48, m_idle_key);
                if (m_zero) begin
                    check("reset_round", round, 0);
                    check("reset_last", last, 0);
                end
            end
            if (valid && ready) hs_count++;
        end
        if (rst) begin
            m_init = 1'b1; m_busy = 1'b0; m_perr = 1'b0;
            m_zero = 1'b1; m_idle_key = '0; m_cnt = 0;
        end else if (m_init) begin
            m_perr = 1'b0;
            if (m_busy) begin
                if (ready) begin
                    m_cnt++;
                    if (m_cnt == 16) begin
                        m_busy = 1'b0;
                        m_idle_key = m_dec ? m_keys[0] : m_c0d0_key;
                    end
                end
            end else if (start) begin
                if (!m_parity_ok(key)) begin
                    m_perr = 1'b1;
                end else begin
                    build(key);
                    m_busy = 1'b1; m_dec = decrypt; m_cnt = 0; m_zero = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_seq(input logic [63:0] k, input logic d);
        key = k; decrypt = d; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_until_idle(input string name, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check(name, busy, 0);
    endtask

    initial begin
        int hs_start;
        int n;
        rst = 1'b1; start = 1'b0; decrypt = 1'b0; key = '0; ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_key", k48, 0);
        check("rst_round", round, 0);
        check("rst_last", last, 0);
        check("rst_perr", perr, 0);

        build(KEY_A);
        check("model_k1", m_keys[0], 48'h1B02EFFC7072);
        check("model_k2", m_keys[1], 48'h79AED9DBC9E5);
        check("model_k16", m_keys[15], 48'hCB3D8B0E17F5);

        // Encrypt, full throughput
        ready = 1'b1;
        begin_seq(KEY_A, 1'b0);
        check("t1_valid", valid, 1);
        check("t1_first_key", k48, 48'h1B02EFFC7072);
        check("t1_first_round", round, 0);
        repeat (15) tick();
        check("t1_last_key", k48, 48'hCB3D8B0E17F5);
        check("t1_last_round", round, 15);
        check("t1_last_flag", last, 1);
        tick();
        check("t1_busy_after", busy, 0);
        check("t1_valid_after", valid, 0);

        // Decrypt, full throughput
        begin_seq(KEY_A, 1'b1);
        check("t2_first_key", k48, 48'hCB3D8B0E17F5);
        check("t2_first_round", round, 15);
        repeat (15) tick();
        check("t2_last_key", k48, 48'h1B02EFFC7072);
        check("t2_last_round", round, 0);
        check("t2_last_flag", last, 1);
        tick();
        check("t2_busy_after", busy, 0);

        // Encrypt under random backpressure
        hs_start = hs_count;
        ready = 1'($urandom_range(0, 1));
        begin_seq(KEY_A, 1'b0);
        n = 0;
        while (busy && n < 300) begin
            ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        check("t3_drained", busy, 0);
        check("t3_handshakes", hs_count - hs_start, 16);

        // Parity rejection on the checking instance only
        ready = 1'b0;
        begin_seq(64'h0, 1'b0);
        check("t4_perr_pulse", perr, 1);
        check("t4_valid", valid, 0);
        check("t4_np_valid", np_valid, 1);
        check("t4_np_key", np_k48, 0);
        check("t4_np_round", np_round, 0);
        check("t4_np_last", np_last, 0);
        check("t4_np_perr", np_perr, 0);
        tick();
        check("t4_perr_clear", perr, 0);
        check("t4_valid_after", valid, 0);
        ready = 1'b1;
        repeat (17) tick();
        check("t4_np_drained", np_busy, 0);
        begin_seq(KEY_A, 1'b0);
        check("t4_accept_valid", valid, 1);
        check("t4_accept_key", k48, 48'h1B02EFFC7072);
        run_until_idle("t4_timeout", 40);

        // Reset after five handshakes
        begin_seq(KEY_A, 1'b0);
        repeat (5) tick();
        check("t5_round_before", round, 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_valid", valid, 0);
        check("t5_busy", busy, 0);
        check("t5_key", k48, 0);
        check("t5_round", round, 0);
        check("t5_last", last, 0);
        begin_seq(KEY_A, 1'b0);
        check("t5_restart_key", k48, 48'h1B02EFFC7072);
        check("t5_restart_round", round, 0);
        run_until_idle("t5_timeout", 40);

        // Start held through EMIT and the final handshake, then into IDLE
        begin_seq(KEY_A, 1'b0);
        key = KEY_B; decrypt = 1'b1; start = 1'b1;
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        check("t6_ended", busy, 0);
        check("t6_idle_gap", valid, 0);
        tick();
        start = 1'b0;
        check("t6_new_valid", valid, 1);
        check("t6_new_round", round, 15);
        key = KEY_A; decrypt = 1'b0;
        run_until_idle("t6_timeout", 40);

        repeat (2) tick();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
